radar_rx_cmd_scheduler: RTL and testbench
=========================================

RADAR_RX_CMD_SCHEDULER -- requirements
Module: radar_rx_cmd_scheduler

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  SR_SCHED_NUM_PULSES  8   settings address, pulse count per burst [15:0]
  SR_SCHED_PRI  9   settings address, pulse repetition interval in clk cycles [31:0]
  SR_SCHED_LEAD  10   settings address, time lead added to vita_time [31:0]
  SR_SCHED_CTRL  11   settings address, write with bit0=1 issues abort
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all logic on rising edge
  reset  in  1  synchronous, active-high reset
  clear  in  1  synchronous soft clear; same effect as reset
  set_stb/set_addr/set_data  in  1/8/32  settings bus
  vita_time  in  64  current time
  awg_init  in  1  single-cycle burst trigger
  awg_data_len  in  32  AWG waveform length, samples
  adc_sample_count  in  32  extra ADC samples after waveform
  cmd_ready  in  1  rx controller command FIFO can accept
  command_o  out  32  {send_imm,chain,reload,stop,numlines[27:0]}
  time_o  out  64  command execute time
  store_command  out  1  one-cycle command write strobe
  busy  out  1  high when state != IDLE
  late_err  out  1  sticky, timed command issued at/after its time
  pulses_issued  out  16  pulse commands issued in current/last burst

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT_PRI, ABORT.
REQ-004 IDLE: awg_init=1 with num_pulses!=0 SHALL latch len = awg_data_len+adc_sample_count+1 (33-bit sum, saturated to 28'hFFFFFFF), next_time = vita_time+lead, clear pulses_issued, go ISSUE; awg_init with num_pulses=0 SHALL be ignored.
REQ-005 awg_init outside IDLE SHALL be ignored; no queued trigger.
REQ-006 ISSUE: when cmd_ready=1, store_command SHALL pulse for exactly one cycle with command_o={send_imm,0,0,0,len} and time_o=next_time, in the same registered cycle; when cmd_ready=0, no strobe, remain.
REQ-007 On each strobe: pulses_issued+1, next_time+=pri (64-bit wrap), pri counter loaded with max(pri,1)-1; if pulses_issued+1==num_pulses go IDLE else WAIT_PRI.
REQ-008 WAIT_PRI: counter decrements each cycle; at 0 go ISSUE (strobe spacing = max(pri,1)+1 cycles minimum, more with backpressure).
REQ-009 num_pulses, pri, lead SHALL be sampled continuously; mid-burst writes take effect at next use.
REQ-010 Abort write (CTRL bit0=1) in ISSUE/WAIT_PRI SHALL go ABORT; in IDLE ignored; abort simultaneous with awg_init in IDLE: awg_init wins.
REQ-011 ABORT: when cmd_ready, one strobe with command_o={1,0,0,1,28'd0}, time_o=0, then IDLE; pulses_issued holds.
REQ-012 Abort SHALL take priority over a same-cycle ISSUE strobe (no pulse command issued that cycle).
REQ-013 busy SHALL be combinational from state.

Reset
REQ-014 reset or clear SHALL force IDLE, command_o=0, time_o=0, store_command=0, late_err=0, pulses_issued=0, internal counters/len/next_time=0; settings registers reset only on reset (num_pulses=0, pri=0, lead=0).
REQ-015 reset mid-burst SHALL drop all pending pulses with no stop command.

Configuration
REQ-016 Macro RADAR_RX_SCHED_TIMED_EN defined: send_imm=0, time_o=next_time, late_err set when strobe cycle has vita_time>=time_o.
REQ-017 Macro undefined: send_imm=1, time_o=0 on pulse commands, lead ignored, late_err tied 0.

Verification
REQ-018 num_pulses=3, pri=10, cmd_ready=1, awg_init with len 100+20 -> 3 strobes 11 cycles apart, numlines=121, pulses_issued=3, then IDLE.
REQ-019 Timed, lead=500, vita_time=1000 at trigger, pri=10 -> time_o=1500,1510,1520; late_err=0.
REQ-020 Timed, lead=0 -> first strobe has time_o<=vita_time, late_err=1 until reset/clear.
REQ-021 cmd_ready held 0 for 20 cycles in ISSUE -> no strobe; strobe on first cycle after cmd_ready=1.
REQ-022 Abort after 2nd pulse of 5 -> stop command 0x90000000 strobed once, IDLE, pulses_issued=2.
REQ-023 awg_data_len=32'hFFFFFFFF, adc_sample_count=5 -> numlines=28'hFFFFFFF.

Source files
------------

// File: rtl/radar_rx_cmd_scheduler.sv
// radar_rx_cmd_scheduler
// Turns a single AWG trigger into a burst of rx-controller commands: one
// command per pulse, spaced by the pulse repetition interval. A settings-bus
// abort write cuts the burst short with a single stop command.
// Optional feature macro: RADAR_RX_SCHED_TIMED_EN. When it is defined,
// commands are timed (time_o = vita_time + lead + k*pri) and late commands set
// late_err. When it is undefined, commands are send-immediate, time_o is 0 and
// late_err stays 0.
module radar_rx_cmd_scheduler #(
    parameter logic [7:0] SR_SCHED_NUM_PULSES = 8'd8,
    parameter logic [7:0] SR_SCHED_PRI        = 8'd9,
    parameter logic [7:0] SR_SCHED_LEAD       = 8'd10,
    parameter logic [7:0] SR_SCHED_CTRL       = 8'd11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [63:0] vita_time,
    input  logic        awg_init,
    input  logic [31:0] awg_data_len,
    input  logic [31:0] adc_sample_count,
    input  logic        cmd_ready,
    output logic [31:0] command_o,
    output logic [63:0] time_o,
    output logic        store_command,
    output logic        busy,
    output logic        late_err,
    output logic [15:0] pulses_issued
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ISSUE    = 2'd1;
    localparam logic [1:0] WAIT_PRI = 2'd2;
    localparam logic [1:0] ABORT    = 2'd3;

    // {send_imm=1, chain=0, reload=0, stop=1, numlines=0}
    localparam logic [31:0] STOP_CMD = 32'h9000_0000;

    logic [1:0]  state;
    logic [15:0] num_pulses;
    logic [31:0] pri;
    logic [31:0] lead;
    logic [31:0] pri_cnt;
    logic [27:0] len;
    logic [63:0] next_time;

    logic        abort_req;
    logic [32:0] len_sum;
    logic [27:0] len_sat;
    logic [31:0] pri_reload;
    logic [15:0] pulses_inc;
    logic        send_imm;
    logic [63:0] start_time;
    logic [63:0] pulse_time;
    logic        late_now;

`ifdef RADAR_RX_SCHED_TIMED_EN
    assign send_imm   = 1'b0;
    assign start_time = vita_time + {32'd0, lead};
    assign pulse_time = next_time;
    assign late_now   = (vita_time >= next_time);
`else
    logic [31:0] unused_lead;
    assign unused_lead = lead;
    assign send_imm    = 1'b1;
    assign start_time  = vita_time;
    assign pulse_time  = 64'd0;
    assign late_now    = 1'b0;
`endif

    // Command length: waveform + extra ADC samples + 1, clamped to the 28-bit numlines field.
    assign len_sum    = {1'b0, awg_data_len} + {1'b0, adc_sample_count} + 33'd1;
    assign len_sat    = (len_sum > 33'h0FFF_FFFF) ? 28'hFFF_FFFF : len_sum[27:0];
    // A PRI of 0 behaves as 1 so the strobe spacing never drops below two cycles.
    assign pri_reload = (pri == 32'd0) ? 32'd0 : pri - 32'd1;
    assign pulses_inc = pulses_issued + 16'd1;
    assign abort_req  = set_stb && (set_addr == SR_SCHED_CTRL) && set_data[0];
    assign busy       = (state != IDLE);

    // Settings registers: written from the settings bus, read live by the scheduler.
    // NOTE: clear deliberately leaves these alone so software need not reprogram after a soft clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_pulses <= 16'd0;
            pri        <= 32'd0;
            lead       <= 32'd0;
        end else if (set_stb) begin
            if (set_addr == SR_SCHED_NUM_PULSES) num_pulses <= set_data[15:0];
            if (set_addr == SR_SCHED_PRI)        pri        <= set_data;
            if (set_addr == SR_SCHED_LEAD)       lead       <= set_data;
        end
    end

    // Burst scheduler: trigger, issue pulses with PRI spacing, abort with a stop command.
    // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state         <= IDLE;
            command_o     <= 32'd0;
            time_o        <= 64'd0;
            store_command <= 1'b0;
            late_err      <= 1'b0;
            pulses_issued <= 16'd0;
            pri_cnt       <= 32'd0;
            len           <= 28'd0;
            next_time     <= 64'd0;
        end else begin
            // NOTE: default-low here makes the write strobe exactly one cycle wide.
            store_command <= 1'b0;
            case (state)
                IDLE: begin
                    if (awg_init && (num_pulses != 16'd0)) begin
                        len           <= len_sat;
                        next_time     <= start_time;
                        pulses_issued <= 16'd0;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (abort_req) begin
                        state <= ABORT;
                    end else if (cmd_ready) begin
                        store_command <= 1'b1;
                        command_o     <= {send_imm, 3'b000, len};
                        time_o        <= pulse_time;
                        late_err      <= late_err | late_now;
                        pulses_issued <= pulses_inc;
                        next_time     <= next_time + {32'd0, pri};
                        pri_cnt       <= pri_reload;
                        state         <= (pulses_inc == num_pulses) ? IDLE : WAIT_PRI;
                    end
                end
                WAIT_PRI: begin
                    if (abort_req) begin
                        state <= ABORT;
                    end else if (pri_cnt == 32'd0) begin
                        state <= ISSUE;
                    end else begin
                        pri_cnt <= pri_cnt - 32'd1;
                    end
                end
                ABORT: begin
                    if (cmd_ready) begin
                        store_command <= 1'b1;
                        command_o     <= STOP_CMD;
                        time_o        <= 64'd0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_radar_rx_cmd_scheduler.sv
// tb_radar_rx_cmd_scheduler
// Self-checking bench. Each burst is first planned from the scheduling rules
// (pulse k may go out no earlier than max(pri,1)+1 cycles after pulse k-1 and
// only on a cycle where cmd_ready is high), then the planned per-cycle outputs
// are compared against the DUT. Works with or without RADAR_RX_SCHED_TIMED_EN.
module tb_radar_rx_cmd_scheduler;

    localparam int MAXE = 400;
    localparam logic [7:0] A_NUM  = 8'd8;
    localparam logic [7:0] A_PRI  = 8'd9;
    localparam logic [7:0] A_LEAD = 8'd10;
    localparam logic [7:0] A_CTRL = 8'd11;
`ifdef RADAR_RX_SCHED_TIMED_EN
    localparam bit TIMED = 1'b1;
`else
    localparam bit TIMED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, clear, set_stb, awg_init, cmd_ready;
    logic [7:0]  set_addr;
    logic [31:0] set_data, awg_data_len, adc_sample_count;
    logic [63:0] vita_time;
    logic [31:0] command_o;
    logic [63:0] time_o;
    logic        store_command, busy, late_err;
    logic [15:0] pulses_issued;

    int n_cmp = 0;
    int n_bad = 0;

    radar_rx_cmd_scheduler dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .vita_time(vita_time), .awg_init(awg_init),
        .awg_data_len(awg_data_len), .adc_sample_count(adc_sample_count),
        .cmd_ready(cmd_ready), .command_o(command_o), .time_o(time_o),
        .store_command(store_command), .busy(busy), .late_err(late_err),
        .pulses_issued(pulses_issued)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    // One clock edge; outputs are then read 1 time unit later, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        step();
        set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
    endtask

    // Program, soft-clear, trigger, and compare every cycle against the planned schedule.
    task automatic run_burst(input string name, input int n, input int p,
                             input logic [31:0] lead, input logic [31:0] dlen,
                             input logic [31:0] alen, input logic [63:0] vbase,
                             input int rmode, input int abort_edge, input bit noise);
        bit          rdy[MAXE];
        bit          e_stb[MAXE];
        logic [31:0] e_cmd[MAXE];
        logic [63:0] e_time[MAXE];
        int          e_pi[MAXE];
        bit          e_busy[MAXE];
        bit          e_late[MAXE];
        logic [63:0] sum;
        logic [63:0] t_k;
        logic [27:0] nl;
        int          s, elig, k, fin_edge, last;
        bit          aborting, done, late;

        write_reg(A_NUM, n);
        write_reg(A_PRI, p);
        write_reg(A_LEAD, lead);
        clear = 1'b1;
        step();
        clear = 1'b0;

        for (int e = 0; e < MAXE; e++) begin
            case (rmode)
                0:       rdy[e] = 1'b1;
                1:       rdy[e] = ($urandom_range(0, 99) < 60) || (e >= 200);
                default: rdy[e] = (e > 20);
            endcase
        end

        sum = 64'(dlen) + 64'(alen) + 64'd1;
        nl  = (sum > 64'h0FFF_FFFF) ? 28'hFFF_FFFF : sum[27:0];
        s   = ((p < 1) ? 1 : p) + 1;
        t_k = vbase + 64'(lead);
        elig = 1; k = 0; aborting = 0; done = 0; late = 0; fin_edge = -1;
        for (int e = 0; e < MAXE; e++) begin
            e_stb[e] = 1'b0; e_cmd[e] = 32'd0; e_time[e] = 64'd0;
            if (e > 0 && !done) begin
                if (e == abort_edge && !aborting) begin
                    aborting = 1'b1;
                end else if (aborting) begin
                    if (rdy[e]) begin
                        e_stb[e] = 1'b1; e_cmd[e] = 32'h9000_0000; e_time[e] = 64'd0;
                        done = 1'b1; fin_edge = e;
                    end
                end else if (e >= elig && rdy[e]) begin
                    e_stb[e] = 1'b1;
                    e_cmd[e] = {~TIMED, 3'b000, nl};
                    e_time[e] = TIMED ? t_k : 64'd0;
                    if (TIMED && (vbase + 64'(e) >= t_k)) late = 1'b1;
                    t_k  = t_k + 64'(p);
                    k++;
                    elig = e + s;
                    if (k == n) begin done = 1'b1; fin_edge = e; end
                end
            end
            e_pi[e] = k; e_busy[e] = !done; e_late[e] = late;
        end
        last = (fin_edge < 0) ? MAXE - 1 : fin_edge + 4;
        if (fin_edge < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s plan: burst does not finish within %0d cycles, want it to", name, MAXE);
        end

        for (int e = 0; e <= last; e++) begin
            awg_init = (e == 0) || (noise && e <= fin_edge && $urandom_range(0, 9) == 0);
            awg_data_len     = (e == 0) ? dlen : $urandom;
            adc_sample_count = (e == 0) ? alen : $urandom;
            cmd_ready = rdy[e];
            vita_time = vbase + 64'(e);
            set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
            if (e == abort_edge) begin
                set_stb = 1'b1; set_addr = A_CTRL; set_data = $urandom | 32'd1;
            end else if (noise && (e == 0 || $urandom_range(0, 7) == 0)) begin
                set_stb = 1'b1; set_addr = A_CTRL;
                set_data = (e == 0) ? ($urandom | 32'd1) : ($urandom & ~32'd1);
            end
            step();
            n_cmp++;
            if (store_command !== e_stb[e]) begin
                n_bad++;
                $display("FAIL %s store_command cyc %0d: got %b want %b", name, e, store_command, e_stb[e]);
            end
            if (e_stb[e]) begin
                n_cmp++;
                if (command_o !== e_cmd[e]) begin
                    n_bad++;
                    $display("FAIL %s command_o cyc %0d: got %h want %h", name, e, command_o, e_cmd[e]);
                end
                n_cmp++;
                if (time_o !== e_time[e]) begin
                    n_bad++;
                    $display("FAIL %s time_o cyc %0d: got %0d want %0d", name, e, time_o, e_time[e]);
                end
            end
            n_cmp++;
            if (pulses_issued !== 16'(e_pi[e])) begin
                n_bad++;
                $display("FAIL %s pulses_issued cyc %0d: got %0d want %0d", name, e, pulses_issued, e_pi[e]);
            end
            n_cmp++;
            if (busy !== e_busy[e]) begin
                n_bad++;
                $display("FAIL %s busy cyc %0d: got %b want %b", name, e, busy, e_busy[e]);
            end
            n_cmp++;
            if (late_err !== e_late[e]) begin
                n_bad++;
                $display("FAIL %s late_err cyc %0d: got %b want %b", name, e, late_err, e_late[e]);
            end
        end
        awg_init = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; awg_init = 1'b1; cmd_ready = 1'b1;
        set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
        awg_data_len = 32'd7; adc_sample_count = 32'd3; vita_time = 64'd55;
        repeat (3) step();
        n_cmp++;
        if ({command_o, time_o, store_command, busy, late_err, pulses_issued} !== 115'd0) begin
            n_bad++;
            $display("FAIL reset outputs: got cmd=%h time=%0d stb=%b busy=%b late=%b pi=%0d want all 0",
                     command_o, time_o, store_command, busy, late_err, pulses_issued);
        end
        reset = 1'b0; awg_init = 1'b0;
        step();
        // num_pulses is 0 after reset, so neither a trigger nor an abort may start anything.
        awg_init = 1'b1;
        step();
        awg_init = 1'b0;
        write_reg(A_CTRL, 32'd1);
        repeat (4) begin
            step();
            n_cmp++;
            if (busy !== 1'b0 || store_command !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle_trigger: got busy=%b stb=%b want 0 0", busy, store_command);
            end
        end
    endtask

    task automatic test_clear();
        write_reg(A_NUM, 32'd2);
        write_reg(A_PRI, 32'd6);
        cmd_ready = 1'b1; awg_init = 1'b1;
        step();
        awg_init = 1'b0;
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_cmp++;
        if ({command_o, time_o, store_command, busy, late_err, pulses_issued} !== 115'd0) begin
            n_bad++;
            $display("FAIL clear outputs: got cmd=%h time=%0d stb=%b busy=%b pi=%0d want all 0",
                     command_o, time_o, store_command, busy, pulses_issued);
        end
        awg_init = 1'b1;
        step();
        awg_init = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_keeps_settings busy: got %b want 1", busy);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        write_reg(A_NUM, 32'd4);
        write_reg(A_PRI, 32'd3);
        clear = 1'b1;
        step();
        clear = 1'b0;
        cmd_ready = 1'b1; awg_init = 1'b1;
        step();
        awg_init = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (store_command !== 1'b0 || busy !== 1'b0 || pulses_issued !== 16'd0 ||
                command_o !== 32'd0 || time_o !== 64'd0) begin
                n_bad++;
                $display("FAIL reset_mid_burst cyc %0d: got stb=%b busy=%b pi=%0d cmd=%h want all 0",
                         i, store_command, busy, pulses_issued, command_o);
            end
            step();
        end
    endtask

    task automatic test_basic_burst();
        run_burst("basic_3x10", 3, 10, 32'd0, 32'd100, 32'd20, 64'd0, 0, -1, 1'b0);
        run_burst("single_pulse", 1, 5, 32'd0, 32'd9, 32'd0, 64'd77, 0, -1, 1'b0);
        run_burst("pri_zero", 4, 0, 32'd3, 32'd1, 32'd1, 64'd200, 0, -1, 1'b0);
        run_burst("pri_one", 3, 1, 32'd3, 32'd2, 32'd2, 64'd300, 0, -1, 1'b0);
    endtask

    task automatic test_timed();
        run_burst("lead_500", 3, 10, 32'd500, 32'd16, 32'd4, 64'd1000, 0, -1, 1'b0);
        run_burst("lead_0_late", 3, 10, 32'd0, 32'd16, 32'd4, 64'd1000, 0, -1, 1'b0);
        run_burst("time_wrap", 3, 10, 32'd5, 32'd16, 32'd4, 64'hFFFF_FFFF_FFFF_FFF0, 0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_burst("ready_low_20", 2, 4, 32'd50, 32'd8, 32'd8, 64'd10, 2, -1, 1'b0);
        run_burst("ready_random", 5, 3, 32'd50, 32'd8, 32'd8, 64'd10, 1, -1, 1'b0);
    endtask

    task automatic test_abort();
        run_burst("abort_in_wait", 5, 4, 32'd100, 32'd30, 32'd2, 64'd0, 0, 8, 1'b0);
        run_burst("abort_beats_issue", 5, 4, 32'd100, 32'd30, 32'd2, 64'd0, 0, 11, 1'b0);
        run_burst("abort_backpressure", 5, 4, 32'd100, 32'd30, 32'd2, 64'd0, 1, 3, 1'b0);
    endtask

    task automatic test_saturation();
        run_burst("sat_ffffffff", 2, 2, 32'd0, 32'hFFFF_FFFF, 32'd5, 64'd0, 0, -1, 1'b0);
        run_burst("no_sat_edge", 1, 2, 32'd0, 32'h0FFF_FFFE, 32'd0, 64'd0, 0, -1, 1'b0);
        run_burst("sat_edge", 1, 2, 32'd0, 32'h0FFF_FFFF, 32'd0, 64'd0, 0, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            int n, p, ab;
            n  = $urandom_range(1, 6);
            p  = $urandom_range(0, 12);
            ab = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 30) : -1;
            run_burst($sformatf("rand%0d", i), n, p, $urandom_range(0, 40), $urandom, $urandom,
                      {$urandom, $urandom}, 1, ab, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_basic_burst();
        test_timed();
        test_backpressure();
        test_abort();
        test_saturation();
        test_random();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
